// File: rtl/tlb_array.sv
// tlb_array: fully-associative TLB storage and lookup for the MMU translation path.
//
// Lookup is combinational. Every cycle the presented VPN/ASID is matched
// against all entries, and the hit PPN, page type and PTE flags are produced.
// Refills from the page table walker go to the lowest invalid entry. When every
// entry is valid, the refill goes to the tree-PLRU victim. TLBFlush invalidates
// every entry at the next rising edge.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   LookupValid, VPN, ASID
//                         lookup request (LookupValid qualifies the PLRU update)
//   TLBWrite, WriteVPN, WriteASID, WritePPN, WritePageType, WriteFlags
//                         refill from the walker
//   TLBFlush              invalidate all entries (sfence.vma)
//   TLBHit, TLBMiss, PPN, HitPageType, PTEFlags
//                         lookup result; all zero when there is no hit
module tlb_array #(
  parameter int ENTRIES   = 8,
  parameter int VPN_BITS  = 36,
  parameter int PPN_BITS  = 44,
  parameter int ASID_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 LookupValid,
  input  logic [VPN_BITS-1:0]  VPN,
  input  logic [ASID_BITS-1:0] ASID,
  input  logic                 TLBWrite,
  input  logic [VPN_BITS-1:0]  WriteVPN,
  input  logic [ASID_BITS-1:0] WriteASID,
  input  logic [PPN_BITS-1:0]  WritePPN,
  input  logic [1:0]           WritePageType,
  input  logic [7:0]           WriteFlags,
  input  logic                 TLBFlush,
  output logic                 TLBHit,
  output logic                 TLBMiss,
  output logic [PPN_BITS-1:0]  PPN,
  output logic [1:0]           HitPageType,
  output logic [7:0]           PTEFlags
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  // Entry storage
  logic [ENTRIES-1:0]   valid_r;
  logic [VPN_BITS-1:0]  vpn_r   [ENTRIES];
  logic [ASID_BITS-1:0] asid_r  [ENTRIES];
  logic [PPN_BITS-1:0]  ppn_r   [ENTRIES];
  logic [1:0]           ptype_r [ENTRIES];
  logic [7:0]           flags_r [ENTRIES];

  // PLRU tree in heap order: node n (1..ENTRIES-1) is stored at bit n-1.
  logic [ENTRIES-2:0]   plru_r;
  logic [ENTRIES-2:0]   plru_next_s;

  logic [ENTRIES-1:0]   match_s;
  logic                 hit_s;
  logic [IDX_BITS-1:0]  hit_idx_s;
  logic [IDX_BITS-1:0]  inv_idx_s;
  logic [IDX_BITS-1:0]  plru_idx_s;
  logic [IDX_BITS-1:0]  victim_s;
  logic [IDX_BITS-1:0]  acc_idx_s;
  logic                 wr_en_s;
  logic                 acc_en_s;

  // Compare mask for a page type: page type p ignores the low 9*p VPN bits.
  function automatic logic [VPN_BITS-1:0] vpn_mask(input logic [1:0] ptype);
    logic [VPN_BITS-1:0] m;
    for (int b = 0; b < VPN_BITS; b++) begin
      m[b] = (b >= 9 * int'(ptype));
    end
    return m;
  endfunction

  // Per-entry match and lowest-index hit selection
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      match_s[i] = valid_r[i]
                 && (flags_r[i][5] || (asid_r[i] == ASID))
                 && (((VPN ^ vpn_r[i]) & vpn_mask(ptype_r[i])) == '0);
    end
    hit_s     = |match_s;
    hit_idx_s = '0;
    // The descending scan lets the lowest matching index win.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit_idx_s = match_s[i] ? IDX_BITS'(i) : hit_idx_s;
    end
  end

  assign TLBHit      = hit_s;
  assign TLBMiss     = LookupValid & ~hit_s;
  assign PPN         = hit_s ? ppn_r[hit_idx_s]   : '0;
  assign HitPageType = hit_s ? ptype_r[hit_idx_s] : 2'b00;
  assign PTEFlags    = hit_s ? flags_r[hit_idx_s] : 8'h00;

  // Victim choice: lowest invalid entry first, otherwise walk the PLRU tree
  always_comb begin : victim_sel
    int node_v;
    inv_idx_s = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      inv_idx_s = (!valid_r[i]) ? IDX_BITS'(i) : inv_idx_s;
    end
    node_v = 1;
    // A node bit of 0 sends the walk to the lower-index child (2n).
    for (int l = 0; l < IDX_BITS; l++) begin
      node_v = 2 * node_v + int'(plru_r[node_v-1]);
    end
    plru_idx_s = IDX_BITS'(node_v - ENTRIES);
    victim_s   = (&valid_r) ? plru_idx_s : inv_idx_s;
  end

  // PLRU next state: point every node on the accessed path away from it.
  // A refill takes priority over a simultaneous hit. A refill dropped by a
  // flush is not an access.
  always_comb begin : plru_upd
    int node_v;
    wr_en_s     = TLBWrite & ~TLBFlush;
    acc_en_s    = wr_en_s | (LookupValid & hit_s);
    acc_idx_s   = wr_en_s ? victim_s : hit_idx_s;
    plru_next_s = plru_r;
    for (int l = 0; l < IDX_BITS; l++) begin
      node_v = (1 << l) + (int'(acc_idx_s) >> (IDX_BITS - l));
      plru_next_s[node_v-1] = ~acc_idx_s[IDX_BITS-1-l];
    end
  end

  // Entry array, valid bits and PLRU state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      plru_r  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_r[i]   <= '0;
        asid_r[i]  <= '0;
        ppn_r[i]   <= '0;
        ptype_r[i] <= 2'b00;
        flags_r[i] <= 8'h00;
      end
    end else begin
      if (TLBFlush) begin
        valid_r <= '0;
      end else if (TLBWrite) begin
        valid_r[victim_s] <= 1'b1;
        vpn_r[victim_s]   <= WriteVPN;
        asid_r[victim_s]  <= WriteASID;
        ppn_r[victim_s]   <= WritePPN;
        ptype_r[victim_s] <= WritePageType;
        flags_r[victim_s] <= WriteFlags;
      end else begin
        valid_r <= valid_r;
      end
      if (acc_en_s) begin
        plru_r <= plru_next_s;
      end else begin
        plru_r <= plru_r;
      end
    end
  end

endmodule

// File: tb/tb_tlb_array.sv
// tb_tlb_array: directed self-checking bench for tlb_array.
// It uses hand-computed expected values and one initial block of linear steps.
module tb_tlb_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        LookupValid;
  logic [35:0] VPN;
  logic [15:0] ASID;
  logic        TLBWrite;
  logic [35:0] WriteVPN;
  logic [15:0] WriteASID;
  logic [43:0] WritePPN;
  logic [1:0]  WritePageType;
  logic [7:0]  WriteFlags;
  logic        TLBFlush;
  logic        TLBHit;
  logic        TLBMiss;
  logic [43:0] PPN;
  logic [1:0]  HitPageType;
  logic [7:0]  PTEFlags;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  tlb_array dut (
    .clk(clk), .reset(reset), .LookupValid(LookupValid), .VPN(VPN), .ASID(ASID),
    .TLBWrite(TLBWrite), .WriteVPN(WriteVPN), .WriteASID(WriteASID),
    .WritePPN(WritePPN), .WritePageType(WritePageType), .WriteFlags(WriteFlags),
    .TLBFlush(TLBFlush), .TLBHit(TLBHit), .TLBMiss(TLBMiss), .PPN(PPN),
    .HitPageType(HitPageType), .PTEFlags(PTEFlags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the given expected values.
  task automatic chk_out(input string tag, input logic eh, input logic em,
                         input logic [43:0] ep, input logic [1:0] et, input logic [7:0] ef);
    chk({tag, ".hit"},   TLBHit,      eh);
    chk({tag, ".miss"},  TLBMiss,     em);
    chk({tag, ".ppn"},   PPN,         ep);
    chk({tag, ".type"},  HitPageType, et);
    chk({tag, ".flags"}, PTEFlags,    ef);
  endtask

  // Present a lookup for one cycle, checking the combinational result mid-cycle.
  task automatic look(input string tag, input logic [35:0] v, input logic [15:0] a,
                      input logic eh, input logic [43:0] ep, input logic [1:0] et,
                      input logic [7:0] ef);
    LookupValid = 1'b1; VPN = v; ASID = a;
    #1;
    chk_out(tag, eh, ~eh, ep, et, ef);
    @(posedge clk); #1;
    LookupValid = 1'b0;
  endtask

  task automatic refill(input logic [35:0] v, input logic [15:0] a, input logic [43:0] p,
                        input logic [1:0] t, input logic [7:0] f);
    TLBWrite = 1'b1; WriteVPN = v; WriteASID = a; WritePPN = p;
    WritePageType = t; WriteFlags = f;
    @(posedge clk); #1;
    TLBWrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [35:0] fvpn(input int i);
    return 36'h100000000 + 36'(i);
  endfunction

  initial begin
    reset = 1'b1; LookupValid = 1'b0; VPN = 36'h0; ASID = 16'h0;
    TLBWrite = 1'b0; WriteVPN = 36'h0; WriteASID = 16'h0; WritePPN = 44'h0;
    WritePageType = 2'd0; WriteFlags = 8'h00; TLBFlush = 1'b0;
    #1;
    chk_out("rst_idle", 1'b0, 1'b0, 44'h0, 2'd0, 8'h00);
    LookupValid = 1'b1; VPN = 36'h123456789; #1;
    chk_out("rst_lookup", 1'b0, 1'b1, 44'h0, 2'd0, 8'h00);
    LookupValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic kilo-page refill and ASID match
    look("t1_miss", 36'h123456789, 16'd5, 1'b0, 44'h0, 2'd0, 8'h00);
    refill(36'h123456789, 16'd5, 44'hABCDE, 2'd0, 8'hCF);
    look("t1_hit",  36'h123456789, 16'd5, 1'b1, 44'hABCDE, 2'd0, 8'hCF);
    look("t1_asid", 36'h123456789, 16'd6, 1'b0, 44'h0, 2'd0, 8'h00);

    // Global giga page
    refill(36'h000040000, 16'd3, 44'h80000, 2'd2, 8'hEF);
    look("t2_hit",  36'h00007FFFF, 16'h1234, 1'b1, 44'h80000, 2'd2, 8'hEF);
    look("t2_miss", 36'h000080000, 16'h1234, 1'b0, 44'h0, 2'd0, 8'h00);

    // PLRU replacement. Hits on entries 0 and 4 leave entry 2 as the victim.
    do_reset();
    for (int i = 0; i < 8; i++) refill(fvpn(i), 16'd7, 44'h100 + 44'(i), 2'd0, 8'hC1);
    look("t3_hit0", fvpn(0), 16'd7, 1'b1, 44'h100, 2'd0, 8'hC1);
    look("t3_hit4", fvpn(4), 16'd7, 1'b1, 44'h104, 2'd0, 8'hC1);
    refill(36'h200000000, 16'd7, 44'h999, 2'd0, 8'hC1);
    look("t3_old2", fvpn(2), 16'd7, 1'b0, 44'h0, 2'd0, 8'h00);
    look("t3_new",  36'h200000000, 16'd7, 1'b1, 44'h999, 2'd0, 8'hC1);
    look("t3_v0", fvpn(0), 16'd7, 1'b1, 44'h100, 2'd0, 8'hC1);
    look("t3_v4", fvpn(4), 16'd7, 1'b1, 44'h104, 2'd0, 8'hC1);
    look("t3_v1", fvpn(1), 16'd7, 1'b1, 44'h101, 2'd0, 8'hC1);
    look("t3_v3", fvpn(3), 16'd7, 1'b1, 44'h103, 2'd0, 8'hC1);

    // Flush and write in the same cycle: the flush wins. A lookup in the
    // flush cycle still sees the old contents.
    TLBFlush = 1'b1; TLBWrite = 1'b1; WriteVPN = 36'h300000000; WriteASID = 16'd7;
    WritePPN = 44'h333; WritePageType = 2'd0; WriteFlags = 8'hC1;
    LookupValid = 1'b1; VPN = fvpn(5); ASID = 16'd7;
    #1;
    chk_out("t4_flushcyc", 1'b1, 1'b0, 44'h105, 2'd0, 8'hC1);
    @(posedge clk); #1;
    TLBFlush = 1'b0; TLBWrite = 1'b0; LookupValid = 1'b0;
    look("t4_wvpn", 36'h300000000, 16'd7, 1'b0, 44'h0, 2'd0, 8'h00);
    look("t4_v0",   fvpn(0), 16'd7, 1'b0, 44'h0, 2'd0, 8'h00);
    look("t4_v5",   fvpn(5), 16'd7, 1'b0, 44'h0, 2'd0, 8'h00);
    look("t4_new",  36'h200000000, 16'd7, 1'b0, 44'h0, 2'd0, 8'h00);

    // A refill is not visible to a lookup in its own cycle.
    TLBWrite = 1'b1; WriteVPN = 36'h0000ABCDE; WriteASID = 16'd2; WritePPN = 44'h4242;
    WritePageType = 2'd0; WriteFlags = 8'h0F;
    LookupValid = 1'b1; VPN = 36'h0000ABCDE; ASID = 16'd2;
    #1;
    chk_out("t5_samecyc", 1'b0, 1'b1, 44'h0, 2'd0, 8'h00);
    @(posedge clk); #1;
    TLBWrite = 1'b0;
    chk_out("t5_next", 1'b1, 1'b0, 44'h4242, 2'd0, 8'h0F);
    // Asynchronous reset mid-cycle clears the outputs immediately.
    #1;
    reset = 1'b1;
    #1;
    chk_out("t5_async_rst", 1'b0, 1'b1, 44'h0, 2'd0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0; LookupValid = 1'b0;
    look("t5_after_rst", 36'h0000ABCDE, 16'd2, 1'b0, 44'h0, 2'd0, 8'h00);

    // Overlapping entries: the lowest index (mega page, entry 1) wins.
    refill(36'h300000000, 16'd9, 44'h1, 2'd0, 8'hC1);
    refill(36'h000000A00, 16'd9, 44'h55400, 2'd1, 8'hCF);
    refill(36'h300000001, 16'd9, 44'h2, 2'd0, 8'hC1);
    refill(36'h000000A05, 16'd9, 44'h777, 2'd0, 8'hC3);
    look("t6_overlap", 36'h000000A05, 16'd9, 1'b1, 44'h55400, 2'd1, 8'hCF);
    look("t6_mega",    36'h000000BFF, 16'd9, 1'b1, 44'h55400, 2'd1, 8'hCF);
    look("t6_out",     36'h000000C00, 16'd9, 1'b0, 44'h0, 2'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
